// File: rtl/ins_loader.sv
// ins_loader: burst loader for an internal instruction byte array with a
// combinational big-endian 32-bit read port.
//
// A load burst is requested with Start while idle. The burst writes
// LenWords*4 bytes, one per accepted InData/InValid handshake, starting at
// the word-aligned BaseAddr. Addresses wrap modulo DEPTH. Done pulses for
// one cycle after the final byte, or right away when LenWords is zero.
//
// Ports:
//   CLK          sole clock, rising edge
//   Reset        synchronous, active-high
//   Start        load request, sampled only while idle
//   BaseAddr     byte start address, bits [1:0] ignored
//   LenWords     number of 32-bit words to load, sampled with Start
//   InData       incoming byte, most-significant byte of each word first
//   InValid      InData valid
//   InReady      loader accepts a byte this cycle (LOAD state)
//   Busy         high in LOAD state
//   Done         one-cycle pulse on burst completion
//   WordsLoaded  complete words written in the current/last burst
//   IAddr        fetch byte address, bits [8:0] used
//   IDataOut     {mem[a], mem[a+1], mem[a+2], mem[a+3]}, indices mod DEPTH
module ins_loader #(
  parameter int unsigned DEPTH = 512
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [8:0]  BaseAddr,
  input  logic [7:0]  LenWords,
  input  logic [7:0]  InData,
  input  logic        InValid,
  output logic        InReady,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  WordsLoaded,
  input  logic [31:0] IAddr,
  output logic [31:0] IDataOut
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [9:0]    cnt, cnt_nxt;
  logic [7:0]    words, words_nxt;
  logic          xfer;

  logic [7:0]    mem [DEPTH];

  // Only the word-aligned part of BaseAddr and the low nine bits of IAddr
  // carry meaning.
  logic unused_bits;
  assign unused_bits = ^{BaseAddr[1:0], IAddr[31:9]};

  // Reduce a byte address into the array range.
  function automatic logic [AW-1:0] wrap(input int unsigned x);
    int unsigned t;
    t = x % DEPTH;
    return t[AW-1:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      words <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      words <= words_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    words_nxt = words;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          words_nxt = '0;
          if (LenWords != '0) begin
            state_nxt = LOAD;
            ptr_nxt   = wrap({23'd0, BaseAddr[8:2], 2'b00});
            cnt_nxt   = {LenWords, 2'b00};
          end else begin
            state_nxt = DONE;
          end
        end
      end
      LOAD: begin
        if (InValid) begin
          xfer    = 1'b1;
          ptr_nxt = wrap(32'(ptr) + 32'd1);
          cnt_nxt = cnt - 10'd1;
          // The fourth byte of a word completes it.
          if (ptr[1:0] == 2'b11) begin
            words_nxt = words + 8'd1;
          end
          if (cnt == 10'd1) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign InReady     = (state == LOAD);
  assign Busy        = (state == LOAD);
  assign Done        = (state == DONE);
  assign WordsLoaded = words;

  // Array has no reset; a byte offered in a reset cycle is dropped.
  always_ff @(posedge CLK) begin
    if (xfer && !Reset) begin
      mem[ptr] <= InData;
    end
  end

  always_comb begin
    IDataOut = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      IDataOut[31-8*k -: 8] = mem[wrap(32'(IAddr[8:0]) + k)];
    end
  end

endmodule
